// File: rtl/hpi_mailbox_engine_if.sv
// hpi_mailbox_engine_if: req/ack word-transaction bus between the mailbox engine and hpi_controller
interface hpi_mailbox_engine_if;
  logic        hpi_req;
  logic        hpi_req_write;
  logic [1:0]  hpi_req_reg;
  logic [15:0] hpi_req_wdata;
  logic        hpi_ack;
  logic [15:0] hpi_rdata;
  modport master (output hpi_req, hpi_req_write, hpi_req_reg, hpi_req_wdata, input hpi_ack, hpi_rdata);
  modport slave (input hpi_req, hpi_req_write, hpi_req_reg, hpi_req_wdata, output hpi_ack, hpi_rdata);
endinterface

// File: rtl/hpi_mailbox_engine.sv
// hpi_mailbox_engine: services the HPI interrupt (STATUS then MAILBOX read into an RX FIFO) and writes outbound mailbox words
module hpi_mailbox_engine #(
  parameter int FIFO_AW = 2,
  parameter int MBX_FLAG_BIT = 0,
  parameter int TIMEOUT_CYC = 255,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hpi_irq,
  hpi_mailbox_engine_if.master hpi,
  input  logic               send_valid,
  output logic               send_ready,
  input  logic [15:0]        send_data,
  output logic               rx_valid,
  output logic [15:0]        rx_data,
  input  logic               rx_pop,
  output logic [FIFO_AW:0]   rx_count,
  output logic               err_timeout,
  input  logic               err_clr
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CMAX = TIMEOUT_CYC > HOLDOFF_CYC ? TIMEOUT_CYC : HOLDOFF_CYC;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, RD_STATUS, RD_MBX, WR_MBX, HOLDOFF} state_t;
  state_t state, state_n;
  logic [1:0] irq_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic req_n, wr_n;
  logic [1:0] reg_n;
  logic [15:0] wd_n;
  logic service_irq, send_fire, xact, done, tmo, push, pop;
  assign service_irq = irq_q[1] && (rx_count < (FIFO_AW+1)'(DEPTH));
  assign send_ready = state == IDLE && !service_irq;
  assign send_fire = send_valid && send_ready;
  assign xact = state == RD_STATUS || state == RD_MBX || state == WR_MBX;
  assign done = hpi.hpi_req && hpi.hpi_ack;
  assign tmo = hpi.hpi_req && !hpi.hpi_ack && cnt == CW'(TIMEOUT_CYC - 1);
  assign push = state == RD_MBX && done;
  assign pop = rx_pop && rx_valid;
  assign rx_valid = rx_count != '0;
  assign rx_data = rx_valid ? mem[rd_ptr] : 16'h0;
  // FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // FSM next state: IRQ service beats outbound send; timeouts always fall into holdoff
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = service_irq ? RD_STATUS : send_fire ? WR_MBX : IDLE;
      RD_STATUS: state_n = tmo ? HOLDOFF : done ? (hpi.hpi_rdata[MBX_FLAG_BIT] ? RD_MBX : HOLDOFF) : RD_STATUS;
      RD_MBX:    state_n = tmo || done ? HOLDOFF : RD_MBX;
      WR_MBX:    state_n = tmo ? HOLDOFF : done ? IDLE : WR_MBX;
      HOLDOFF:   state_n = cnt == CW'(HOLDOFF_CYC - 1) ? IDLE : HOLDOFF;
      default:   state_n = IDLE;
    endcase
  end
  // FSM outputs: next request fields; a chained request idles one cycle after the previous ack
  always_comb begin
    req_n = state == IDLE ? service_irq || send_fire : xact && (hpi.hpi_req ? !(done || tmo) : 1'b1);
    wr_n = state_n == WR_MBX;
    reg_n = state_n == RD_MBX || state_n == WR_MBX ? 2'b01 : 2'b11;
    wd_n = send_fire ? send_data : hpi.hpi_req_wdata;
    cnt_n = state_n != state || (!hpi.hpi_req && req_n) ? '0 : (hpi.hpi_req && !hpi.hpi_ack) || state == HOLDOFF ? cnt + CW'(1) : cnt;
  end
  // registered request fields, shared wait/holdoff counter, IRQ synchronizer, sticky timeout flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hpi.hpi_req <= 1'b0;
      hpi.hpi_req_write <= 1'b0;
      hpi.hpi_req_reg <= 2'b11;
      hpi.hpi_req_wdata <= 16'h0;
      cnt <= '0;
      irq_q <= 2'b00;
      err_timeout <= 1'b0;
    end else begin
      hpi.hpi_req <= req_n;
      hpi.hpi_req_write <= wr_n;
      hpi.hpi_req_reg <= reg_n;
      hpi.hpi_req_wdata <= wd_n;
      cnt <= cnt_n;
      irq_q <= {irq_q[0], hpi_irq};
      err_timeout <= tmo || (err_timeout && !err_clr);
    end
  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(push);
      rd_ptr <= rd_ptr + FIFO_AW'(pop);
      rx_count <= rx_count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  // RX FIFO storage, written with the MAILBOX read data on its ack
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= hpi.hpi_rdata;
endmodule
